// File: rtl/mac_stream_unit.sv
// rtl/mac_stream_unit.sv - streaming multiply-accumulate engine with per-run length, sign mode and overflow handling
module mac_stream_unit #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int ACC_W = 24,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             stop,
  input  logic [CW-1:0]    len,
  input  logic             signed_mode,
  input  logic             in_valid,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic             in_ready,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [ACC_W-1:0] result,
  output logic [ACC_W-1:0] acc,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int XW = ACC_W + 1;

  state_t          state;
  logic [CW-1:0]   len_q;
  logic            signed_q;

  logic [2*DW-1:0] a_x, b_x, prod;
  logic [XW-1:0]   p_ext, acc_x, sum;
  logic            ovf;
  logic [ACC_W-1:0] acc_nx;
  logic [CW-1:0]   count_nx;

  assign in_ready = busy & ~stop;
  assign count_nx = count + 1'b1;

  // Operands are extended to 2*DW before one multiplier; the low 2*DW bits
  // are the correct product in both signed and unsigned interpretations.
  always_comb begin
    a_x    = signed_q ? {{DW{a_in[DW-1]}}, a_in} : {{DW{1'b0}}, a_in};
    b_x    = signed_q ? {{DW{b_in[DW-1]}}, b_in} : {{DW{1'b0}}, b_in};
    prod   = a_x * b_x;
    p_ext  = {{(XW-2*DW){signed_q & prod[2*DW-1]}}, prod};
    acc_x  = {signed_q & acc[ACC_W-1], acc};
    sum    = acc_x + p_ext;
    ovf    = signed_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    acc_nx = sum[ACC_W-1:0];
    if (ovf && (SAT != 0)) begin
      if (!signed_q)
        acc_nx = '1;
      else if (sum[ACC_W])
        acc_nx = {1'b1, {(ACC_W-1){1'b0}}};
      else
        acc_nx = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idle       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      len_q      <= '0;
      signed_q   <= 1'b0;
      acc        <= '0;
      count      <= '0;
      result     <= '0;
      count_last <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            idle     <= 1'b0;
            if (len == '0) begin
              result     <= '0;
              count_last <= '0;
              state      <= S_DONE;
              done       <= 1'b1;
            end else begin
              len_q    <= len;
              signed_q <= signed_mode;
              state    <= S_RUN;
              busy     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            result     <= acc;
            count_last <= count;
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else if (in_valid) begin
            acc   <= acc_nx;
            count <= count_nx;
            if (ovf)
              overflow <= 1'b1;
            if (count_nx == len_q) begin
              result     <= acc_nx;
              count_last <= count_nx;
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          idle  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_stream_unit.md
# mac_stream_unit

Parametrised successor to the 8-bit fixed-length MAC engine. It accumulates the products of a run of operand pairs into a wide accumulator. Operand width, count width and accumulator width are parameters. Run length is programmed per run. Operands arrive over a valid/ready handshake, signed or unsigned arithmetic is selected per run, and overflow either saturates or wraps. It sits between an operand source (FIFO or sensor front end) and a result consumer, and is started and observed by a system controller through go/stop/idle/busy/done.

## Interface
- `DW`, 8: operand width (a and b).
- `CW`, 8: run-length / beat-counter width.
- `ACC_W`, 24: accumulator and result width; must satisfy ACC_W ≥ 2·DW.
- `SAT`, 1: 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request; level, sampled only in IDLE.
- `stop`  in  1  abort request; level, sampled only in RUN.
- `len`  in  CW  beats per run; latched on go.
- `signed_mode`  in  1  1 = two's-complement operands; latched on go.
- `in_valid`  in  1  operand pair valid.
- `a_in`, `b_in`  in  DW  operands.
- `in_ready`  out  1  unit accepts a pair this cycle.
- `idle`, `busy`, `done`  out  1  state flags; `done` is a 1-cycle pulse.
- `overflow`  out  1  sticky per run; held until the next run starts.
- `result`  out  ACC_W  final accumulator; held until the next run completes.
- `acc`  out  ACC_W  live accumulator.
- `count`  out  CW  beats accepted in the current run.
- `count_last`  out  CW  beats accepted in the last completed run.

## Operation
- FSM states are IDLE, RUN and DONE. Outputs are `idle`=(IDLE), `busy`=(RUN) and `done`=(DONE).
- **IDLE, go=1, len≠0:** go to RUN.
  - Latch `len` and `signed_mode`.
  - Clear `acc`, `count` and `overflow`.
- **IDLE, go=1, len=0:** go straight to DONE.
  - Set `result`=0 and `count_last`=0.
  - Clear `acc`, `count` and `overflow`.
- **RUN, beat acceptance:** `in_ready` = RUN & ~stop (combinational). A beat is accepted when in_valid & in_ready.
  - On each accepted beat, `acc` ← acc + ext(a·b) and `count` ← count+1.
  - The product is 2·DW bits. It is sign-extended in signed mode and zero-extended otherwise.
- **RUN, final beat:** when the accepted beat makes count+1 = latched len, go to DONE on the same edge.
  - Load `result` ← new acc value.
  - Load `count_last` ← count+1.
- **RUN, stop=1:** go to DONE.
  - No beat is accepted that cycle, even if in_valid=1; stop has priority.
  - Load `result` ← acc and `count_last` ← count.
- **DONE:** always returns to IDLE after one cycle. `go` is ignored in DONE.
- **Overflow, signed mode:** the signed ACC_W range is exceeded.
- **Overflow, unsigned mode:** a carry occurs out of ACC_W.
- **On overflow:**
  - SAT=1: clamp to max/min of the range (unsigned min is not reachable).
  - SAT=0: wrap.
  - In both cases `overflow` is set and stays set.
- Once saturated, later beats continue to add and clamp.
- `a_in`, `b_in` and `signed_mode` are ignored outside accepted beats and the go cycle respectively.

## Timing
- **Reset (async assert, sync deassert by integrator):**
  - State = IDLE, so `idle`=1.
  - `busy`, `done`, `in_ready` and `overflow` = 0.
  - `acc`, `result`, `count` and `count_last` = 0.
- **Reset during RUN/DONE:** the run is aborted with no `done` pulse, and all outputs take their reset values immediately.
- **Start latency:** if go=1 at edge k in IDLE, then `busy`=1 and `in_ready`=1 (if stop=0) from k+1.
- **Accumulate latency:** an accepted beat at edge e is visible on `acc`/`count` after e. There is no pipeline.
- **Completion latency:** if the final beat is accepted at edge e, `done`=1 for the cycle after e, and `result`/`count_last` are valid that same cycle. `idle`=1 from edge e+1.
- **Throughput:** one beat per cycle while in_valid=1. A run of len N with no bubbles takes N busy cycles plus 1 done cycle.
- **Zero-length run:** if go is asserted with len=0 at edge k, `done` is high for the cycle after k and `busy` never asserts.
- **Back-to-back runs:** go held high re-starts in the IDLE cycle after DONE, so the minimum gap between runs is 1 idle cycle.

## Test plan
1. **Unsigned run:** DW=8, ACC_W=24, unsigned, len=3, pairs (2,3), (4,5), (10,10) on consecutive cycles → `result`=126, `count_last`=3, `done` 1 cycle after the third beat, `overflow`=0.
2. **Signed run:** signed, len=2, pairs (0xFD=−3, 7) and (2, 5) → `result`=0xFFFFF5 (−11), `overflow`=0.
3. **Bubbles:** len=4 with in_valid low for 2 cycles between each beat, pairs (1,1)×4 → `count` steps only on accepted beats, `result`=4, busy for 10 cycles.
4. **Stop priority:** stop asserted with in_valid=1 after 2 accepted beats of (3,3), len=5 → third pair not accepted (`in_ready`=0 that cycle), `done` pulse, `result`=18, `count_last`=2.
5. **Overflow, both modes:** ACC_W=17, unsigned, len=3, pairs (255,255)×3.
   - SAT=1 → `result`=131071, `overflow`=1.
   - SAT=0 → `result`=64003, `overflow`=1.
6. **Edge cases:**
   - go with len=0 → `done` 1 cycle later, `result`=0, `count_last`=0, no busy.
   - Then start len=4 and pull reset_n low after 2 beats → `idle`=1 and all other outputs 0 immediately, no `done`.
